// File: rtl/soc_cisc_pkg.sv
// Shared types and constants for the CISC memory-bus path: FSM state
// encoding, operation encoding and default bus widths.
package soc_cisc_pkg;

   localparam int ADDR_W_DEFAULT = 8;
   localparam int DATA_W_DEFAULT = 8;

   // Wait-state counter width and the largest wait count it can hold
   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 15;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_WAIT     = 2'd2,
      ST_COMPLETE = 2'd3
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that times the memory wait states. o_expired is
// high when the count is on its last wait cycle (1) or already empty (0).
module wait_counter
   import soc_cisc_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_count;

   // Load takes priority over decrement; the count saturates at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_expired = (r_count <= CNT_W'(1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus sequencer feeding the MDR. Accepts one read or write from the
// control unit, runs the external synchronous memory with a fixed number of
// wait states, and on reads hands the returned byte to the MDR with a
// one-cycle load strobe. Writes win over reads when both are requested.
// Optional build macro MEM_READY_EN adds a mem_ready input that stretches
// the wait phase until the memory signals ready.
module mem_bus_ctrl
   import soc_cisc_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEFAULT,
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] mdr_data,
   output logic              mdr_ld,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_READY_EN
   input  logic              mem_ready,
`endif
   output logic              mem_cs,
   output logic              mem_we
);

   if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > WAIT_MAX)) begin : g_wait_range
      $error("mem_bus_ctrl: WAIT_CYCLES must be within 0..15");
   end

   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   state_e            r_state;
   op_e               r_op;
   logic              r_busy;
   logic              r_done;
   logic              r_mdr_ld;
   logic [DATA_W-1:0] r_mdr_data;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_cs;
   logic              r_mem_we;

   logic              w_expired;
   logic              w_finish;

   wait_counter u_wait_counter (
      .clk        (clk),
      .reset      (reset),
      .i_load     (r_state == ST_SETUP),
      .i_load_val (WAIT_LD),
      .i_en       (r_state == ST_WAIT),
      .o_expired  (w_expired)
   );

   // The access ends at this edge: wait states used up (and memory ready)
`ifdef MEM_READY_EN
   assign w_finish = (r_state == ST_WAIT) && w_expired && mem_ready;
`else
   assign w_finish = ((r_state == ST_SETUP) && (WAIT_CYCLES == 0)) ||
                     ((r_state == ST_WAIT) && w_expired);
`endif

   // Access sequencer with all bus and MDR outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_RD;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_mdr_ld    <= 1'b0;
         r_mdr_data  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_cs    <= 1'b0;
         r_mem_we    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done   <= 1'b0;
               r_mdr_ld <= 1'b0;
               r_busy   <= 1'b0;
               if (req_wr || req_rd) begin
                  r_op        <= req_wr ? OP_WR : OP_RD;
                  r_mem_addr  <= req_addr;
                  r_mem_wdata <= req_wdata;
                  r_busy      <= 1'b1;
                  r_mem_cs    <= 1'b1;
                  r_mem_we    <= req_wr;
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP, ST_WAIT: begin
               if (w_finish) begin
                  r_state  <= ST_COMPLETE;
                  r_done   <= 1'b1;
                  r_mdr_ld <= (r_op == OP_RD);
                  r_mem_cs <= 1'b0;
                  r_mem_we <= 1'b0;
                  if (r_op == OP_RD) begin
                     r_mdr_data <= mem_rdata;
                  end
               end else if (r_state == ST_SETUP) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_COMPLETE: begin
               r_state  <= ST_IDLE;
               r_done   <= 1'b0;
               r_mdr_ld <= 1'b0;
               r_busy   <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign mdr_ld    = r_mdr_ld;
   assign mdr_data  = r_mdr_data;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_cs    = r_mem_cs;
   assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: a default instance (2 wait states)
// driven through a small memory model with a completion scoreboard, plus a
// zero-wait-state instance for the short-latency / mem_ready case.
module tb_mem_bus_ctrl;

   typedef struct packed {
      logic       ld;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_rd = 1'b0, req_wr = 1'b0;
   logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
   logic       busy, done, mdr_ld, mem_cs, mem_we;
   logic [7:0] mdr_data, mem_addr, mem_wdata, mem_rdata;

   logic       req_rd0 = 1'b0, req_wr0 = 1'b0;
   logic       busy0, done0, mdr_ld0, mem_cs0, mem_we0;
   logic [7:0] mdr_data0, mem_addr0, mem_wdata0, mem_rdata0;
`ifdef MEM_READY_EN
   logic       mem_ready  = 1'b1;
   logic       mem_ready0 = 1'b0;
`endif

   logic [7:0] mem    [0:255];
   logic [7:0] shadow [0:255];
   exp_t       exp_q[$];
   logic [7:0] exp_mdr = 8'h00;
   int         n_vec = 0, n_err = 0, n_done = 0;

   always #5 clk = ~clk;

   mem_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
      .mdr_data(mdr_data), .mdr_ld(mdr_ld), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_READY_EN
      .mem_ready(mem_ready),
`endif
      .mem_cs(mem_cs), .mem_we(mem_we));

   mem_bus_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_rd(req_rd0), .req_wr(req_wr0),
      .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy0), .done(done0),
      .mdr_data(mdr_data0), .mdr_ld(mdr_ld0), .mem_addr(mem_addr0),
      .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
`ifdef MEM_READY_EN
      .mem_ready(mem_ready0),
`endif
      .mem_cs(mem_cs0), .mem_we(mem_we0));

   // Synchronous memory model shared by both instances
   assign mem_rdata  = mem[mem_addr];
   assign mem_rdata0 = mem[mem_addr0];
   always @(posedge clk) if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: every done pulse retires the oldest expected completion
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_done", done, 1'b0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("sb_mdr_ld", mdr_ld, e.ld);
            check_val("sb_mdr_data", mdr_data, e.data);
         end
         n_done++;
      end
   end

   task automatic push_exp(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
      if (wr) begin
         shadow[a] = d;
         exp_q.push_back('{ld: 1'b0, data: exp_mdr});
      end else if (rd) begin
         exp_mdr = shadow[a];
         exp_q.push_back('{ld: 1'b1, data: exp_mdr});
      end
   endtask

   // Present a request for one edge and check the accept-edge outputs
   task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
      push_exp(rd, wr, a, d);
      @(posedge clk);
      #1;
      check_val("acc_busy", busy, 1'b1);
      check_val("acc_cs", mem_cs, 1'b1);
      check_val("acc_we", mem_we, wr);
      check_val("acc_addr", mem_addr, a);
      req_rd = 1'b0; req_wr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (k == budget) check_val("idle_timeout", busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, cs_cnt, t1, t2, d0;
      logic flag, seen;

      for (int i = 0; i < 256; i++) begin
         mem[i]    = 8'(i) ^ 8'hC6;
         shadow[i] = 8'(i) ^ 8'hC6;
      end
      mem[0] = 8'h00; shadow[0] = 8'h00;

      // Reset state
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_mdr_ld", mdr_ld, 1'b0);
      check_val("rst_cs_we", {mem_cs, mem_we}, 2'b00);
      check_val("rst_data", {mdr_data, mem_addr, mem_wdata}, 24'h0);
      reset = 1'b0;

      // Read 0x10 -> 0xD6, latency and chip-select window
      issue(1'b1, 1'b0, 8'h10, 8'h00);
      lat = 0; cs_cnt = 0; flag = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_cs) begin cs_cnt++; flag = flag | mem_we; end
         if (done) begin lat = k; break; end
      end
      check_val("rd_latency", lat, 4);
      check_val("rd_cs_cycles", cs_cnt, 3);
      check_val("rd_we_low", flag, 1'b0);
      @(negedge clk);
      check_val("rd_busy_after", busy, 1'b0);
      check_val("rd_done_after", done, 1'b0);
      repeat (3) @(negedge clk);
      check_val("rd_hold", mdr_data, 8'hD6);

      // Write 0x55 to 0x21, bus values while selected
      issue(1'b0, 1'b1, 8'h21, 8'h55);
      flag = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_cs) flag = flag & mem_we & (mem_addr == 8'h21) & (mem_wdata == 8'h55);
         if (done) break;
      end
      check_val("wr_bus", flag, 1'b1);
      wait_idle(20);
      check_val("wr_mdr_kept", mdr_data, 8'hD6);

      // Read back the written location
      issue(1'b1, 1'b0, 8'h21, 8'h00);
      wait_idle(20);
      check_val("rdback", mdr_data, 8'h55);

      // Simultaneous read and write: one write, no pending read
      d0 = n_done;
      issue(1'b1, 1'b1, 8'h40, 8'h02);
      wait_idle(20);
      repeat (3) @(negedge clk);
      check_val("sim_no_pending", busy, 1'b0);
      check_val("sim_one_done", n_done - d0, 1);
      check_val("sim_mem", mem[8'h40], 8'h02);

      // Request during WAIT is ignored
      d0 = n_done;
      issue(1'b1, 1'b0, 8'h33, 8'h00);
      repeat (2) @(negedge clk);
      req_rd = 1'b1; req_addr = 8'h44;
      @(negedge clk);
      req_rd = 1'b0;
      wait_idle(20);
      repeat (6) @(negedge clk);
      check_val("busy_ignore_done", n_done - d0, 1);
      check_val("busy_ignore_idle", busy, 1'b0);

      // Held request: back-to-back access period
      t1 = 0; t2 = 0; seen = 1'b0;
      @(negedge clk);
      req_rd = 1'b1; req_addr = 8'h05;
      push_exp(1'b1, 1'b0, 8'h05, 8'h00);
      push_exp(1'b1, 1'b0, 8'h05, 8'h00);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            if (t1 == 0) t1 = k;
            else begin t2 = k; break; end
         end
         if ((t1 != 0) && !busy) seen = 1'b1;
         if (seen && busy) req_rd = 1'b0;
      end
      req_rd = 1'b0;
      check_val("b2b_period", t2 - t1, 5);
      wait_idle(20);

      // Reset in the middle of a read
      issue(1'b1, 1'b0, 8'h60, 8'h00);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_val("abort_cs_we", {mem_cs, mem_we}, 2'b00);
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_done_ld", {done, mdr_ld}, 2'b00);
      exp_q.delete();
      exp_mdr = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_val("abort_quiet", {busy, done}, 2'b00);
      issue(1'b1, 1'b0, 8'h00, 8'h00);
      wait_idle(20);
      check_val("post_abort_rd", mdr_data, 8'h00);

      // Zero wait states on the second instance
      @(negedge clk);
      req_rd0 = 1'b1; req_addr = 8'h10; req_wdata = 8'h77;
      @(posedge clk);
      #1;
      req_rd0 = 1'b0;
      check_val("w0_busy", busy0, 1'b1);
      check_val("w0_cs_we", {mem_cs0, mem_we0}, 2'b10);
      check_val("w0_wdata", mem_wdata0, 8'h77);
`ifdef MEM_READY_EN
      flag = 1'b0;
      repeat (5) begin
         @(negedge clk);
         flag = flag | done0;
      end
      check_val("w0_no_done_wo_ready", flag, 1'b0);
      mem_ready0 = 1'b1;
      @(negedge clk);
      check_val("w0_ready_done", done0, 1'b1);
      check_val("w0_ready_ld", mdr_ld0, 1'b1);
      check_val("w0_ready_data", mdr_data0, 8'hD6);
`else
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done0) begin lat = k; break; end
      end
      check_val("w0_latency", lat, 2);
      check_val("w0_ld", mdr_ld0, 1'b1);
      check_val("w0_data", mdr_data0, 8'hD6);
`endif
      @(negedge clk);
      check_val("w0_idle", {busy0, done0, mdr_ld0}, 3'b000);

      check_val("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
